// File: rtl/led_pattern_engine.sv
// LED pattern engine: rotate left/right, bounce and bar fill on a WIDTH-bit bank.
// Step timing comes from a prescaler clock-enable plus a 2-bit speed sub-counter.
module led_pattern_engine #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 25000000,
  parameter int PW       = 25
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BAR    = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MSB_HOT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] led_q, led_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [1:0]       sub_q, sub_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             dir_q, dir_d;      // 0 = dot moving toward LSB
  logic             phase_q, phase_d;  // 0 = filling, 1 = draining
  mode_e            mode_q, mode_d;
  logic             do_step;
  logic             onehot;

  function automatic logic [WIDTH-1:0] start_pat(input logic [1:0] m);
    return (m == 2'b11) ? '0 : MSB_HOT;
  endfunction

  assign onehot = (led_q != '0) && ((led_q & (led_q - ONE)) == '0);

  always_ff @(posedge CLK) begin
    if (!rst) begin
      led_q   <= start_pat(mode);
      pre_q   <= '0;
      sub_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
      mode_q  <= mode_e'(mode);
    end else begin
      led_q   <= led_d;
      pre_q   <= pre_d;
      sub_q   <= sub_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    led_d   = led_q;
    pre_d   = pre_q;
    sub_d   = sub_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    do_step = 1'b0;

    // A mode change restarts the pattern and outranks any coincident step.
    if (mode_e'(mode) != mode_q) begin
      mode_d  = mode_e'(mode);
      led_d   = start_pat(mode);
      pre_d   = '0;
      sub_d   = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
    end else if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (sub_q >= speed) begin
          sub_d   = '0;
          do_step = 1'b1;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end

      if (do_step) begin
        step_d = 1'b1;
        case (mode_q)
          MODE_ROTL, MODE_ROTR: begin
            if (!onehot) begin
              led_d  = MSB_HOT;
              wrap_d = 1'b1;
            end else begin
              led_d  = (mode_q == MODE_ROTL) ? {led_q[WIDTH-2:0], led_q[WIDTH-1]}
                                             : {led_q[0], led_q[WIDTH-1:1]};
              wrap_d = (led_d == MSB_HOT);
            end
          end
          MODE_BOUNCE: begin
            if (!onehot) begin
              led_d  = MSB_HOT;
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end else if (!dir_q) begin
              led_d = led_q >> 1;
              if (led_d[0]) dir_d = 1'b1;
            end else begin
              led_d = led_q << 1;
              if (led_d[WIDTH-1]) begin
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end
            end
          end
          default: begin
            if (!phase_q) begin
              led_d = {led_q[WIDTH-2:0], 1'b1};
              if (led_d == '1) phase_d = 1'b1;
            end else begin
              led_d = {led_q[WIDTH-2:0], 1'b0};
              if (led_d == '0) begin
                phase_d = 1'b0;
                wrap_d  = 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign led  = led_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
Parametrised LED pattern generator driving a WIDTH-bit LED bank from the board clock. Four selectable patterns: rotate left, rotate right, bounce, bar fill. Runtime speed select and pause. Fully synchronous to CLK: step timing comes from an internal prescaler clock-enable, with no derived clocks. Sits between the board switch inputs and the LED pins.

Parameters:
WIDTH, 8, number of LEDs (>= 2)
PRESCALE, 25000000, CLK cycles per base tick (>= 2); 4 in simulation
PW, 25, prescaler counter width; must satisfy 2^PW >= PRESCALE

Ports:
CLK    input   1      system clock
rst    input   1      synchronous reset, active-low
en     input   1      1 = run, 0 = pause (hold all state)
mode   input   2      00 rotate left, 01 rotate right, 10 bounce, 11 bar fill
speed  input   2      step period = PRESCALE*(speed+1) CLK cycles
led    output  WIDTH  LED pattern, registered
step   output  1      1-cycle pulse, coincident with each led update
wrap   output  1      1-cycle pulse, coincident with led returning to the mode start pattern

Behaviour:
- Reset is rst, synchronous, active-low, on clock CLK. It dominates all other inputs, including mid-step and mid-mode-change.
- Reset values:
  - led = start pattern of the current mode.
  - step = 0, wrap = 0.
  - Prescaler = 0, sub-counter = 0.
  - Bounce direction = toward LSB.
  - mode_q = mode.
- Start patterns: modes 00/01/10 use a one-hot MSB (1 << (WIDTH-1)). Mode 11 uses all zeros.
- Prescaler:
  - Counts 0..PRESCALE-1 while en = 1 and raises an internal tick at PRESCALE-1, then returns to 0.
  - Sub-counter (2-bit) advances on each tick.
  - A step occurs on the tick where sub-counter >= speed; the sub-counter then clears.
  - Using >= means lowering speed mid-count steps at the next tick, never waiting a full wrap.
- Step update: on a step cycle, led takes its next value on the following edge. step = 1 in the same cycle the new led value appears.
- Rotate left: led <= {led[WIDTH-2:0], led[WIDTH-1]}.
- Rotate right: led <= {led[0], led[WIDTH-1:1]}.
- Both rotate modes: wrap when the new led equals the MSB one-hot, i.e. every WIDTH steps.
- Bounce:
  - The one-hot dot moves toward the LSB.
  - On reaching bit 0 the direction flips, so the next step goes to bit 1. On reaching the MSB it flips back.
  - The direction flip is registered together with the led value that lands on the end bit.
  - Period is 2*WIDTH-2 steps; wrap when the dot returns to the MSB.
- Bar fill:
  - Fill phase: shift ones in from the LSB, led <= {led[WIDTH-2:0], 1'b1}, until all ones.
  - Drain phase: shift zeros in, led <= {led[WIDTH-2:0], 1'b0}, until all zeros.
  - Phase flag toggles on reaching all-ones and on reaching all-zeros.
  - Period is 2*WIDTH steps; wrap when led returns to zero.
- Mode change: mode is compared with the registered mode_q every cycle. On the first cycle mode != mode_q:
  - led <= new start pattern; prescaler, sub-counter, bounce direction and fill phase clear.
  - mode_q <= mode.
  - No step or wrap pulse.
  - This takes priority over a coincident step. It applies even while en = 0.
- Pause: with en = 0, prescaler, sub-counter, led and all flags hold, and step/wrap stay 0. Resuming continues the count exactly where it stopped.
- Robustness: in modes 00/01/10, if led is ever not one-hot (e.g. after an SEU), the next step loads the start pattern and pulses wrap.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
All scenarios use WIDTH=8, PRESCALE=4.
1. Reset: hold rst=0 for 3 cycles with mode=00 -> led=8'h80, step=0, wrap=0. With mode=11 held during reset -> led=8'h00.
2. Rotate left: mode=00, speed=0, en=1.
   - Required: step every 4 cycles; led 80,01,02,04,...,40,80.
   - Required: wrap only with the 8th step (led=80).
   - Then set speed=3 -> step spacing 16 cycles.
3. Rotate right: mode=01 -> led 80,40,20,...,01,80; wrap on the 8th step.
4. Bounce: mode=10 -> led 80,40,...,01,02,...,40,80 (14 steps); wrap on step 14; exactly one step at led=01.
5. Bar fill: mode=11 -> led 00,01,03,07,...,FF,FE,FC,...,80,00; wrap on step 16.
6. Control events:
   - en=0 for 10 cycles mid-pattern -> led frozen, no step; spacing resumes seamlessly.
   - Switch mode 00->10 while led=04 -> led=80 on the next edge, no step.
   - rst=0 coincident with a step cycle -> reset values win.
